text_cursor_ctrl: RTL and testbench

TEXT_CURSOR_CTRL -- requirements
Module: text_cursor_ctrl

---
 rtl/text_pkg.sv | 39 +++
 rtl/char_fifo.sv | 55 +++++
 rtl/text_cursor_ctrl.sv | 145 ++++++++++++++
 tb/tb_text_cursor_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Purpose: shared text-screen geometry, control codes and FSM encoding for the cursor controller.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package text_pkg;

  // Screen geometry in character cells and glyph size in pixels.
  localparam int COLS    = 80;
  localparam int ROWS    = 30;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  // Shift amounts that turn a cell index into a pixel coordinate.
  localparam int X_SHIFT = $clog2(GLYPH_W);
  localparam int Y_SHIFT = $clog2(GLYPH_H);

  // Cursor counter widths and their last legal values.
  localparam int          COL_W   = 7;
  localparam int          ROW_W   = 5;
  localparam logic [6:0]  MAX_COL = 7'(COLS - 1);
  localparam logic [4:0]  MAX_ROW = 5'(ROWS - 1);

  // Control codes handled by the decoder.
  localparam logic [6:0] BS    = 7'h08;
  localparam logic [6:0] CR    = 7'h0D;
  localparam logic [6:0] FF    = 7'h0C;
  localparam logic [6:0] SPACE = 7'h20;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_DRAW   = 2'd2;
  localparam logic [1:0] ST_STEP   = 2'd3;

  // Printable ASCII range that produces a glyph.
  function automatic logic is_printable(input logic [6:0] code);
    return (code >= 7'h20) && (code <= 7'h7E);
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Purpose: small synchronous FIFO buffering character codes ahead of the cursor FSM.
// Latency: a push is visible at head one cycle later; head is read combinationally from storage.
// Backpressure: pushes are dropped while full and pops ignored while empty; callers gate on full/empty.
module char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/text_cursor_ctrl.sv
// Purpose: turns a stream of ASCII codes into glyph draw requests while tracking an 80x30 text cursor.
// Latency: a code pushed into an empty buffer with the FSM idle raises draw_req two edges later.
// Backpressure: char_ready drops when the buffer is full; draw_req holds until the plotter pulses draw_done.
module text_cursor_ctrl #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [2:0] FG_COLOUR  = 3'b111
) (
  input  logic       clk,
  input  logic       reset_n,      // active-high despite the name
  input  logic       char_valid,
  input  logic [6:0] char_code,
  output logic       char_ready,
  output logic       draw_req,
  output logic [9:0] draw_x,
  output logic [8:0] draw_y,
  output logic [6:0] draw_char,
  output logic [2:0] draw_colour,
  input  logic       draw_done,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  import text_pkg::*;

  logic [1:0]       state;
  logic [6:0]       char_reg;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic             fifo_full;
  logic             fifo_empty;
  logic [6:0]       fifo_head;
  logic             fifo_pop;

  logic [COL_W-1:0] adv_col;
  logic [ROW_W-1:0] adv_row;
  logic [COL_W-1:0] bs_col;
  logic [ROW_W-1:0] bs_row;

  char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (7)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset_n),
    .push      (char_valid),
    .push_data (char_code),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Only the idle FSM consumes the buffer, one code at a time.
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

  // Candidate cursor positions: forward advance and backspace retreat, both with wrap.
  always_comb begin
    adv_col = col + COL_W'(1);
    adv_row = row;
    if (col == MAX_COL) begin
      adv_col = '0;
      adv_row = (row == MAX_ROW) ? '0 : row + ROW_W'(1);
    end
    bs_col = col - COL_W'(1);
    bs_row = row;
    if (col == '0) begin
      if (row == '0) begin
        bs_col = '0;
      end else begin
        bs_col = MAX_COL;
        bs_row = row - ROW_W'(1);
      end
    end
  end

  // Main FSM with cursor counters and registered draw coordinates.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= ST_IDLE;
      char_reg  <= '0;
      col       <= '0;
      row       <= '0;
      draw_x    <= '0;
      draw_y    <= '0;
      draw_char <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            char_reg <= fifo_head;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_printable(char_reg)) begin
            draw_x    <= 10'(col) << X_SHIFT;
            draw_y    <= 9'(row) << Y_SHIFT;
            draw_char <= char_reg;
            state     <= ST_DRAW;
          end else if (char_reg == BS) begin
            // Step back first so the erase lands on the cell being deleted.
            col       <= bs_col;
            row       <= bs_row;
            draw_x    <= 10'(bs_col) << X_SHIFT;
            draw_y    <= 9'(bs_row) << Y_SHIFT;
            draw_char <= SPACE;
            state     <= ST_DRAW;
          end else if (char_reg == CR) begin
            col   <= '0;
            row   <= (row == MAX_ROW) ? '0 : row + ROW_W'(1);
            state <= ST_IDLE;
          end else if (char_reg == FF) begin
            col   <= '0;
            row   <= '0;
            state <= ST_IDLE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DRAW: begin
          if (draw_done) state <= ST_STEP;
        end
        ST_STEP: begin
          // Backspace already moved the cursor before drawing.
          if (char_reg != BS) begin
            col <= adv_col;
            row <= adv_row;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign draw_req    = (state == ST_DRAW);
  assign draw_colour = FG_COLOUR;
  assign cursor_col  = col;
  assign cursor_row  = row;
  assign char_ready  = !fifo_full;
  assign busy        = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Purpose: directed self-checking bench for text_cursor_ctrl with an expected-draw scoreboard.
// Latency: checks the two-edge push-to-draw_req latency explicitly.
// Backpressure: exercises a full buffer with draw_done held low, then drains it.
module tb_text_cursor_ctrl;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [6:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       char_valid = 1'b0;
  logic [6:0] char_code = '0;
  logic       char_ready;
  logic       draw_req;
  logic [9:0] draw_x;
  logic [8:0] draw_y;
  logic [6:0] draw_char;
  logic [2:0] draw_colour;
  logic       draw_done = 1'b0;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  int   vectors = 0;
  int   miscompares = 0;
  int   mcol = 0;
  int   mrow = 0;
  exp_t exp_q[$];
  exp_t last_draw;

  always #10 clk = ~clk;

  text_cursor_ctrl #(
    .FIFO_DEPTH (8),
    .FG_COLOUR  (3'b111)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .char_valid  (char_valid),
    .char_code   (char_code),
    .char_ready  (char_ready),
    .draw_req    (draw_req),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .draw_char   (draw_char),
    .draw_colour (draw_colour),
    .draw_done   (draw_done),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b1;
    char_valid = 1'b0;
    draw_done  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    mcol = 0;
    mrow = 0;
    exp_q.delete();
  endtask

  task automatic push_char(input logic [6:0] code);
    int i;
    for (i = 0; i < 200; i++) begin
      if (char_ready) break;
      @(negedge clk);
    end
    if (i == 200) check("push_timeout", 32'd1, 32'd0);
    char_valid = 1'b1;
    char_code  = code;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic service(input int delay);
    int   i;
    exp_t e;
    for (i = 0; i < 100; i++) begin
      if (draw_req) break;
      @(negedge clk);
    end
    check("draw_req_seen", 32'(draw_req), 32'd1);
    if (draw_req) begin
      check("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("draw_x", 32'(draw_x), 32'(e.x));
        check("draw_y", 32'(draw_y), 32'(e.y));
        check("draw_char", 32'(draw_char), 32'(e.c));
        check("draw_colour", 32'(draw_colour), 32'd7);
      end
      last_draw = '{x: draw_x, y: draw_y, c: draw_char};
      repeat (delay) @(negedge clk);
      check("draw_hold", 32'(draw_req), 32'd1);
      draw_done = 1'b1;
      @(negedge clk);
      draw_done = 1'b0;
      check("draw_req_drop", 32'(draw_req), 32'd0);
    end
  endtask

  task automatic wait_idle(output bit saw_draw);
    saw_draw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (draw_req) saw_draw = 1'b1;
      if (!busy) break;
      @(negedge clk);
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  // Push one code, service any draw it produces, and compare the cursor with the bench model.
  task automatic type_char(input logic [6:0] code);
    bit draws;
    bit saw;
    draws = 1'b0;
    if (code >= 7'h20 && code <= 7'h7E) begin
      exp_q.push_back('{x: 10'(mcol * 8), y: 9'(mrow * 16), c: code});
      draws = 1'b1;
      if (mcol == 79) begin
        mcol = 0;
        mrow = (mrow == 29) ? 0 : mrow + 1;
      end else begin
        mcol = mcol + 1;
      end
    end else if (code == 7'h08) begin
      if (mcol == 0 && mrow == 0) begin
        mcol = 0;
      end else if (mcol == 0) begin
        mcol = 79;
        mrow = mrow - 1;
      end else begin
        mcol = mcol - 1;
      end
      exp_q.push_back('{x: 10'(mcol * 8), y: 9'(mrow * 16), c: 7'h20});
      draws = 1'b1;
    end else if (code == 7'h0D) begin
      mcol = 0;
      mrow = (mrow == 29) ? 0 : mrow + 1;
    end else if (code == 7'h0C) begin
      mcol = 0;
      mrow = 0;
    end
    push_char(code);
    if (draws) begin
      service(2);
      wait_idle(saw);
    end else begin
      wait_idle(saw);
      check("no_draw", 32'(saw), 32'd0);
    end
    check("cursor_col", 32'(cursor_col), 32'(mcol));
    check("cursor_row", 32'(cursor_row), 32'(mrow));
  endtask

  initial begin
    bit saw;

    // Reset state.
    do_reset();
    check("rst_draw_req", 32'(draw_req), 32'd0);
    check("rst_draw_x", 32'(draw_x), 32'd0);
    check("rst_draw_y", 32'(draw_y), 32'd0);
    check("rst_draw_char", 32'(draw_char), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_char_ready", 32'(char_ready), 32'd1);
    check("rst_col", 32'(cursor_col), 32'd0);
    check("rst_row", 32'(cursor_row), 32'd0);

    // Single 'A' with explicit latency and a 5-cycle ack delay.
    char_valid = 1'b1;
    char_code  = 7'h41;
    exp_q.push_back('{x: 10'd0, y: 9'd0, c: 7'h41});
    @(negedge clk);
    char_valid = 1'b0;
    check("lat_after_n", 32'(draw_req), 32'd0);
    @(negedge clk);
    check("lat_after_n1", 32'(draw_req), 32'd0);
    @(negedge clk);
    check("lat_after_n2", 32'(draw_req), 32'd1);
    service(5);
    wait_idle(saw);
    check("A_col", 32'(cursor_col), 32'd1);
    check("A_row", 32'(cursor_row), 32'd0);

    // A full row of 80 printable characters.
    do_reset();
    for (int i = 0; i < 80; i++) type_char(7'(8'h21 + 8'(i)));
    check("row_last_x", 32'(last_draw.x), 32'd632);
    check("row_last_y", 32'(last_draw.y), 32'd0);
    check("row_end_col", 32'(cursor_col), 32'd0);
    check("row_end_row", 32'(cursor_row), 32'd1);

    // Backspace wrapping from (0,1) to (79,0).
    type_char(7'h08);
    check("bs_wrap_x", 32'(last_draw.x), 32'd632);
    check("bs_wrap_y", 32'(last_draw.y), 32'd0);
    check("bs_wrap_char", 32'(last_draw.c), 32'h20);
    check("bs_wrap_col", 32'(cursor_col), 32'd79);
    check("bs_wrap_row", 32'(cursor_row), 32'd0);

    // Backspace at the origin erases (0,0) and stays put.
    do_reset();
    type_char(7'h08);
    check("bs_org_x", 32'(last_draw.x), 32'd0);
    check("bs_org_y", 32'(last_draw.y), 32'd0);
    check("bs_org_char", 32'(last_draw.c), 32'h20);
    check("bs_org_col", 32'(cursor_col), 32'd0);
    check("bs_org_row", 32'(cursor_row), 32'd0);

    // Carriage return from the last row wraps; form feed homes.
    do_reset();
    for (int i = 0; i < 29; i++) type_char(7'h0D);
    for (int i = 0; i < 5; i++) type_char(7'h61);
    check("pre_cr_col", 32'(cursor_col), 32'd5);
    check("pre_cr_row", 32'(cursor_row), 32'd29);
    type_char(7'h0D);
    check("cr_wrap_col", 32'(cursor_col), 32'd0);
    check("cr_wrap_row", 32'(cursor_row), 32'd0);
    for (int i = 0; i < 10; i++) type_char(7'h0D);
    for (int i = 0; i < 40; i++) type_char(7'h7E);
    check("pre_ff_col", 32'(cursor_col), 32'd40);
    check("pre_ff_row", 32'(cursor_row), 32'd10);
    type_char(7'h0C);
    check("ff_col", 32'(cursor_col), 32'd0);
    check("ff_row", 32'(cursor_row), 32'd0);
    type_char(7'h01);  // discarded control code

    // Buffer fill with draw_done held low: ready drops only after the 9th push.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      char_valid = 1'b1;
      char_code  = 7'(8'h30 + 8'(k));
      exp_q.push_back('{x: 10'((k - 1) * 8), y: 9'd0, c: 7'(8'h30 + 8'(k))});
      @(negedge clk);
      check($sformatf("fill_ready_%0d", k), 32'(char_ready), (k < 9) ? 32'd1 : 32'd0);
    end
    char_valid = 1'b0;
    for (int k = 0; k < 9; k++) service(1);
    wait_idle(saw);
    check("fill_col", 32'(cursor_col), 32'd9);
    check("fill_row", 32'(cursor_row), 32'd0);
    check("fill_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a draw.
    do_reset();
    push_char(7'h5A);
    for (int i = 0; i < 20; i++) begin
      if (draw_req) break;
      @(negedge clk);
    end
    check("mid_pre_req", 32'(draw_req), 32'd1);
    #3 reset_n = 1'b1;
    #1;
    check("mid_req_async", 32'(draw_req), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ready", 32'(char_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_post_col", 32'(cursor_col), 32'd0);
    check("mid_post_row", 32'(cursor_row), 32'd0);
    check("mid_post_req", 32'(draw_req), 32'd0);
    check("mid_post_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
